// File: rtl/cpu_pkg.sv
// Shared CPU definitions: multiply/divide opcodes, sequencer states and datapath width.
`default_nettype none

package cpu_pkg;

    localparam int MD_W = 32;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_t;

    typedef enum logic [1:0] {
        MD_IDLE = 2'b00,
        MD_RUN  = 2'b01,
        MD_FIX  = 2'b10
    } md_state_t;

endpackage

`default_nettype wire

// File: rtl/md_iter_core.sv
// One combinational step of shift/add multiply or restoring divide on the {hi,lo} accumulator.
`default_nettype none

module md_iter_core
    import cpu_pkg::*;
#(
    parameter int W = MD_W
) (
    input  logic         is_div,
    input  logic [W-1:0] acc_hi,
    input  logic [W-1:0] acc_lo,
    input  logic [W-1:0] m,
    output logic [W-1:0] nxt_hi,
    output logic [W-1:0] nxt_lo
);

    logic [W:0] sum;
    logic [W:0] shifted;
    logic [W:0] diff;

    always_comb begin
        sum     = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, m} : '0);
        shifted = {acc_hi, acc_lo[W-1]};
        diff    = shifted - {1'b0, m};
        nxt_hi  = '0;
        nxt_lo  = '0;
        if (is_div) begin
            // Borrow out (diff[W]) means the trial subtract failed: keep the shifted remainder.
            nxt_hi = diff[W] ? shifted[W-1:0] : diff[W-1:0];
            nxt_lo = {acc_lo[W-2:0], ~diff[W]};
        end else begin
            nxt_hi = sum[W:1];
            nxt_lo = {sum[0], acc_lo[W-1:1]};
        end
    end

endmodule

`default_nettype wire

// File: rtl/hilo_md_seq.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer owning the architectural HI/LO registers.
`default_nettype none

module hilo_md_seq
    import cpu_pkg::*;
#(
    parameter int W    = MD_W,
    parameter int ITER = W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [1:0]   op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         wr_hi,
    input  logic         wr_lo,
    input  logic [W-1:0] wdata,
    input  logic         cancel,
    output logic [W-1:0] hi,
    output logic [W-1:0] lo,
    output logic         stall,
    output logic         done,
    output logic         div_zero
);

    localparam int CW = $clog2(ITER);

    md_state_t       state, state_nxt;
    logic [CW-1:0]   cnt;
    logic            is_div, sign_a, sign_b, dz;
    logic [W-1:0]    m, acc_hi, acc_lo;
    logic [W-1:0]    step_hi, step_lo;

    logic            in_div, in_signed;
    logic [W-1:0]    mag_a, mag_b;
    logic [W-1:0]    res_hi, res_lo;
    logic [2*W-1:0]  prod, prod_neg;
    logic            commit;

    assign in_div    = (op == MD_DIV) || (op == MD_DIVU);
    assign in_signed = (op == MD_MULT) || (op == MD_DIV);
    assign mag_a     = (in_signed && a[W-1]) ? -a : a;
    assign mag_b     = (in_signed && b[W-1]) ? -b : b;
    assign commit    = (state == MD_FIX) && !cancel;

    md_iter_core #(.W(W)) u_core (
        .is_div (is_div),
        .acc_hi (acc_hi),
        .acc_lo (acc_lo),
        .m      (m),
        .nxt_hi (step_hi),
        .nxt_lo (step_lo)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= MD_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            MD_IDLE: if (start) state_nxt = (in_div && b == '0) ? MD_FIX : MD_RUN;
            MD_RUN: begin
                if (cancel)                       state_nxt = MD_IDLE;
                else if (cnt == CW'(ITER - 1))    state_nxt = MD_FIX;
            end
            MD_FIX:  state_nxt = MD_IDLE;
            default: state_nxt = MD_IDLE;
        endcase
    end

    // Sign correction; for divide-by-zero the accumulator already holds {a, all ones}.
    always_comb begin
        prod     = {acc_hi, acc_lo};
        prod_neg = -prod;
        res_hi   = acc_hi;
        res_lo   = acc_lo;
        if (!dz) begin
            if (is_div) begin
                res_lo = (sign_a ^ sign_b) ? -acc_lo : acc_lo;
                res_hi = sign_a ? -acc_hi : acc_hi;
            end else if (sign_a ^ sign_b) begin
                {res_hi, res_lo} = prod_neg;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt      <= '0;
            is_div   <= 1'b0;
            sign_a   <= 1'b0;
            sign_b   <= 1'b0;
            dz       <= 1'b0;
            m        <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            hi       <= '0;
            lo       <= '0;
            stall    <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            stall <= (state_nxt != MD_IDLE);
            done  <= 1'b0;
            case (state)
                MD_IDLE: begin
                    if (start) begin
                        cnt      <= '0;
                        is_div   <= in_div;
                        sign_a   <= in_signed & a[W-1];
                        sign_b   <= in_signed & b[W-1];
                        dz       <= in_div && (b == '0);
                        div_zero <= 1'b0;
                        if (in_div && b == '0) begin
                            m      <= '0;
                            acc_hi <= a;
                            acc_lo <= '1;
                        end else if (in_div) begin
                            m      <= mag_b;
                            acc_hi <= '0;
                            acc_lo <= mag_a;
                        end else begin
                            m      <= mag_a;
                            acc_hi <= '0;
                            acc_lo <= mag_b;
                        end
                    end else begin
                        if (wr_hi) hi <= wdata;
                        if (wr_lo) lo <= wdata;
                    end
                end
                MD_RUN: begin
                    acc_hi <= step_hi;
                    acc_lo <= step_lo;
                    cnt    <= cnt + CW'(1);
                end
                MD_FIX: begin
                    if (commit) begin
                        hi   <= res_hi;
                        lo   <= res_lo;
                        done <= 1'b1;
                        if (dz) div_zero <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_hilo_md_seq.sv
// Self-checking bench for hilo_md_seq: directed corner cases plus random ops against an arithmetic model.
`default_nettype none

module tb_hilo_md_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] a = '0, b = '0, wdata = '0;
    logic        wr_hi = 1'b0, wr_lo = 1'b0, cancel = 1'b0;
    logic [31:0] hi, lo;
    logic        stall, done, div_zero;

    int errors = 0;
    int checks = 0;

    logic [31:0] m_hi = '0, m_lo = '0;
    logic        m_dz = 1'b0;

    hilo_md_seq #(.W(32), .ITER(32)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .wr_hi(wr_hi), .wr_lo(wr_lo), .wdata(wdata), .cancel(cancel),
        .hi(hi), .lo(lo), .stall(stall), .done(done), .div_zero(div_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Returns {HI, LO} from plain integer arithmetic.
    function automatic logic [63:0] ref_md(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        longint      sx, sy, q, r;
        logic [63:0] ux, uy, res;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = {32'b0, x};
        uy = {32'b0, y};
        res = '0;
        case (o)
            2'd0: res = sx * sy;
            2'd1: res = ux * uy;
            default: begin
                if (y == 0) res = {x, 32'hFFFF_FFFF};
                else if (o == 2'd2) begin
                    q = sx / sy;
                    r = sx % sy;
                    res = {r[31:0], q[31:0]};
                end else begin
                    res = {32'(ux % uy), 32'(ux / uy)};
                end
            end
        endcase
        return res;
    endfunction

    task automatic do_op(input string tag, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         input bit wr_start, input bit wr_run, input int cancel_at);
        logic [63:0] exp;
        int          n, exp_cycles;
        bit          bad;
        bit          dz0;
        exp        = ref_md(o, x, y);
        dz0        = o[1] && (y == 0);
        exp_cycles = dz0 ? 1 : 33;
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        if (wr_start) begin wr_hi = 1'b1; wr_lo = 1'b1; wdata = 32'hDEAD_BEEF; end
        @(negedge clk);
        start = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0;
        chk({tag, "_dz_clr"}, div_zero, 1'b0);
        m_dz = 1'b0;
        n = 0; bad = 1'b0;
        while (stall === 1'b1 && n < 100) begin
            n++;
            if (hi !== m_hi || lo !== m_lo || done !== 1'b0) bad = 1'b1;
            if (wr_run) begin
                wr_hi = (n == 3); wr_lo = (n == 3); wdata = 32'h5555_AAAA;
                start = (n == 4);
            end
            cancel = (n == cancel_at);
            @(negedge clk);
        end
        cancel = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0; start = 1'b0;
        chk({tag, "_hold"}, bad, 1'b0);
        if (cancel_at > 0) begin
            chk({tag, "_cyc"}, n, cancel_at);
            chk({tag, "_nodone"}, done, 1'b0);
            chk({tag, "_res"}, {hi, lo}, {m_hi, m_lo});
            chk({tag, "_dz"}, div_zero, m_dz);
        end else begin
            chk({tag, "_cyc"}, n, exp_cycles);
            chk({tag, "_done"}, done, 1'b1);
            {m_hi, m_lo} = exp;
            m_dz = dz0;
            chk({tag, "_res"}, {hi, lo}, {m_hi, m_lo});
            chk({tag, "_dz"}, div_zero, m_dz);
            @(negedge clk);
            chk({tag, "_done1"}, done, 1'b0);
        end
    endtask

    initial begin
        logic [1:0]  ro;
        logic [31:0] ra, rb;

        // Reset state
        #12;
        chk("rst", {hi, lo, stall, done, div_zero}, '0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        do_op("multu_ff_2", 2'd1, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0, 0);
        chk("multu_ff_2_val", {hi, lo}, 64'h0000_0001_FFFF_FFFE);
        do_op("mult_m3_7", 2'd0, 32'hFFFF_FFFD, 32'd7, 1'b0, 1'b0, 0);
        chk("mult_m3_7_val", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
        do_op("div_m7_2", 2'd2, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, 0);
        chk("div_m7_2_val", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        do_op("divu_z", 2'd3, 32'd100, 32'd0, 1'b0, 1'b0, 0);
        chk("divu_z_val", {hi, lo, div_zero}, {32'd100, 32'hFFFF_FFFF, 1'b1});
        do_op("div_ovf", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 0);
        chk("div_ovf_val", {hi, lo}, 64'h0000_0000_8000_0000);

        // MTHI, then MTHI+MTLO together
        wr_hi = 1'b1; wdata = 32'h1234;
        @(negedge clk);
        wr_hi = 1'b0; m_hi = 32'h1234;
        chk("mthi", {hi, lo}, {m_hi, m_lo});
        wr_hi = 1'b1; wr_lo = 1'b1; wdata = 32'h0BAD_F00D;
        @(negedge clk);
        wr_hi = 1'b0; wr_lo = 1'b0; m_hi = 32'h0BAD_F00D; m_lo = 32'h0BAD_F00D;
        chk("mthi_mtlo", {hi, lo}, {m_hi, m_lo});

        // Writes at start and during RUN are dropped
        do_op("multu_wr", 2'd1, 32'd9, 32'd11, 1'b1, 1'b1, 0);

        // Cancel mid-RUN, in FIX, and on a divide-by-zero FIX
        do_op("cancel_run", 2'd3, 32'd1000, 32'd7, 1'b0, 1'b0, 10);
        chk("cancel_run_stall", stall, 1'b0);
        do_op("cancel_fix", 2'd0, 32'h1234_5678, 32'hFFFF_0001, 1'b0, 1'b0, 33);
        do_op("divu_z2", 2'd3, 32'd55, 32'd0, 1'b0, 1'b0, 0);
        do_op("cancel_dz", 2'd2, 32'd77, 32'd0, 1'b0, 1'b0, 1);

        // Cancel in IDLE has no effect
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        @(negedge clk);
        chk("cancel_idle", {hi, lo, stall}, {m_hi, m_lo, 1'b0});

        // Asynchronous reset mid-RUN
        start = 1'b1; op = 2'd0; a = 32'd123; b = 32'd456;
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        #2 rst = 1'b0;
        #1 chk("arst", {hi, lo, stall, done, div_zero}, '0);
        m_hi = '0; m_lo = '0; m_dz = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        do_op("multu_6_7", 2'd1, 32'd6, 32'd7, 1'b0, 1'b0, 0);
        chk("multu_6_7_val", {hi, lo}, 64'd42);

        // Random ops
        for (int i = 0; i < 16; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 5)) : $urandom;
            if ($urandom_range(0, 1) == 1) rb = -rb;
            do_op("rand", ro, ra, rb, 1'b0, 1'b0, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/hilo_md_seq.md
Name: hilo_md_seq

Overview:
- Multi-cycle multiply/divide sequencer that owns the architectural HI/LO registers for the single-cycle-execute MIPS CPU.
- Accepts a MULT/MULTU/DIV/DIVU request from the control unit and iterates a shared 32-step shift/add-subtract datapath.
- Holds the fetch/execute pipeline via a stall output until results commit.
- Also services MTHI/MTLO writes and supplies HI/LO to the register-file writeback mux.

Parameters:
- W, 32, operand/result width (HI and LO are each W bits).
- ITER, W, iteration count of the RUN state; must equal W.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  asynchronous, active-low reset (asserted when 0).
- start  input  1  single-cycle request pulse; sampled only in IDLE.
- op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start.
- a  input  W  rs operand (multiplicand / dividend).
- b  input  W  rt operand (multiplier / divisor).
- wr_hi  input  1  MTHI strobe; honoured only in IDLE without start.
- wr_lo  input  1  MTLO strobe; same rule as wr_hi.
- wdata  input  W  data for wr_hi/wr_lo.
- cancel  input  1  abort an in-flight op (pipeline flush).
- hi  output  W  HI register.
- lo  output  W  LO register.
- stall  output  1  high whenever state != IDLE.
- done  output  1  one-cycle pulse when HI/LO commit from an op.
- div_zero  output  1  sticky flag, set by a DIV/DIVU with b==0; cleared by the next start.

Behaviour:
- Reset (rst==0, any time, including mid-op):
  - hi=0, lo=0, stall=0, done=0, div_zero=0, state=IDLE.
  - Iteration counter and working registers cleared.
- FSM states: IDLE, RUN, FIX.
- IDLE:
  - start at edge E0: latch op and magnitudes of a/b (signed ops take abs; sign bits saved); clear div_zero.
  - If op is a divide and b==0, go to FIX. Otherwise go to RUN with cnt=0.
- RUN:
  - One iteration per cycle; cnt increments 0..ITER-1.
  - Leaves for FIX on the edge where cnt==ITER-1, i.e. edge E32 for W=32.
- FIX:
  - Apply sign correction.
  - Write HI/LO at edge E33, pulse done for the following cycle, return to IDLE.
- Latency: normal op gives 33 cycles from the start edge to result visible; divide-by-zero gives 1 cycle.
- stall: registered, 1 from the cycle after E0 until the FIX→IDLE edge. The control unit holds the issuing instruction out of execute while stall=1.
- Multiply:
  - Shift-add on magnitudes, 2W-bit product {HI,LO}.
  - Signed result is negated (two's complement over 2W bits) when sign(a)^sign(b).
  - MULTU uses raw operands with no correction.
- Divide:
  - Restoring division on magnitudes: LO=quotient, HI=remainder.
  - Signed: quotient negated if sign(a)^sign(b); remainder takes the sign of a (truncation toward zero).
  - DIV 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0 (wrap, no trap).
- Divide by zero: HI=a (original), LO=all ones, div_zero=1, done pulses.
- cancel in RUN or FIX: return to IDLE next edge; HI/LO unchanged; no done; div_zero unchanged.
- Simultaneous events:
  - start and wr_hi/wr_lo in the same IDLE cycle: start wins, writes dropped.
  - wr_hi and wr_lo together: both written with wdata.
  - start, wr_hi and wr_lo while not IDLE: ignored.
  - cancel in IDLE: no effect.
  - cancel in the same cycle as the FIX commit edge: cancel wins, no commit.
- hi/lo outputs are always the committed registers. Intermediate values are never visible.

Decomposition:
- Shared package cpu_pkg contains:
  - md_op_t enum {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU}.
  - md_state_t enum {MD_IDLE, MD_RUN, MD_FIX}.
  - Constant MD_W = 32.
- One sub-module, md_iter_core, is the combinational single-step unit:
  - Multiply: conditional add + shift.
  - Divide: trial subtract + shift.
  - Operates on the working accumulator.
- hilo_md_seq keeps the FSM, counter, sign bookkeeping and HI/LO.

Test Plan:
- MULTU a=0xFFFFFFFF b=2, then 33 cycles -> hi=0x00000001, lo=0xFFFFFFFE; done pulses once; stall high for exactly 33 cycles.
- MULT a=-3 (0xFFFFFFFD) b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; DIV a=-7 b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU a=100 b=0 -> 1 cycle later hi=100, lo=0xFFFFFFFF, div_zero=1; next start clears div_zero.
- MTHI wdata=0x1234 in IDLE -> hi=0x1234 next cycle. Then start MULTU with wr_lo asserted in the same cycle -> wr_lo ignored. During RUN, wr_hi ignored.
- Start DIVU 1000/7, assert cancel at cycle 10 -> IDLE next edge, stall=0, hi/lo keep prior values, no done.
- Start MULT, drive rst=0 at cycle 15 (mid-RUN, asynchronous, between edges) -> hi=lo=0 and stall=0 immediately. After release, a new MULTU 6*7 gives lo=42, hi=0.
